// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at issue, captures CDB results,
// retires in program order to the register file and raises a one-cycle flush on mispredict.
module reorder_buffer #(
    parameter int ROB_INDEX_BIT = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_is_store,
    input  logic                     issue_is_br,
    input  logic [31:0]              issue_pc,
    input  logic [31:0]              issue_pred_pc,
    input  logic                     issue_ready,
    input  logic [31:0]              issue_value,
    output logic [ROB_INDEX_BIT-1:0] issue_rob_id,
    output logic                     full,
    input  logic                     wb_valid,
    input  logic [ROB_INDEX_BIT-1:0] wb_rob_id,
    input  logic [31:0]              wb_value,
    input  logic [31:0]              wb_next_pc,
    input  logic [ROB_INDEX_BIT-1:0] q1_id,
    input  logic [ROB_INDEX_BIT-1:0] q2_id,
    output logic                     q1_ready,
    output logic                     q2_ready,
    output logic [31:0]              q1_value,
    output logic [31:0]              q2_value,
    output logic [4:0]               set_value_id,
    output logic [31:0]              set_value,
    output logic [ROB_INDEX_BIT-1:0] set_value_rob_id,
    output logic                     commit_store,
    output logic [ROB_INDEX_BIT-1:0] commit_store_rob_id,
    output logic                     clear,
    output logic [31:0]              redirect_pc
);

    localparam int SIZE = 2 ** ROB_INDEX_BIT;
    localparam logic [ROB_INDEX_BIT-1:0] IDX_ZERO = {ROB_INDEX_BIT{1'b0}};
    localparam logic [ROB_INDEX_BIT-1:0] IDX_ONE  = {{(ROB_INDEX_BIT-1){1'b0}}, 1'b1};
    localparam logic [ROB_INDEX_BIT:0]   CNT_ZERO = {(ROB_INDEX_BIT+1){1'b0}};
    localparam logic [ROB_INDEX_BIT:0]   CNT_ONE  = {{ROB_INDEX_BIT{1'b0}}, 1'b1};
    localparam logic [ROB_INDEX_BIT:0]   CNT_FULL = {1'b1, {ROB_INDEX_BIT{1'b0}}};

    logic        busy_r     [SIZE];
    logic        ready_r    [SIZE];
    logic [4:0]  rd_r       [SIZE];
    logic [31:0] value_r    [SIZE];
    logic        is_store_r [SIZE];
    logic        is_br_r    [SIZE];
    logic [31:0] pc_r       [SIZE];
    logic [31:0] pred_pc_r  [SIZE];
    logic [31:0] next_pc_r  [SIZE];

    logic [ROB_INDEX_BIT-1:0] head_r;
    logic [ROB_INDEX_BIT-1:0] tail_r;
    logic [ROB_INDEX_BIT:0]   count_r;
    logic                     clear_r;
    logic [31:0]              redirect_pc_r;

    logic issue_acc_s;
    logic wb_acc_s;
    logic fire_s;
    logic mispredict_s;
    logic unused_pc_s;

    // Entry PC is kept for trace/debug visibility; no retirement path consumes it.
    assign unused_pc_s = ^pc_r[head_r];

    assign full         = (count_r == CNT_FULL);
    assign issue_rob_id = tail_r;
    assign clear        = clear_r;
    assign redirect_pc  = redirect_pc_r;

    assign issue_acc_s  = issue_valid & ~full & ~clear_r & rdy_in;
    assign wb_acc_s     = wb_valid & busy_r[wb_rob_id] & ~clear_r & rdy_in;
    assign fire_s       = rdy_in & ~clear_r & (count_r != CNT_ZERO) & ready_r[head_r];
    assign mispredict_s = fire_s & is_br_r[head_r] & (next_pc_r[head_r] != pred_pc_r[head_r]);

    // Commit interface: retire the head entry when its result is available.
    always_comb begin
        set_value_id        = 5'd0;
        set_value           = 32'd0;
        set_value_rob_id    = head_r;
        commit_store        = 1'b0;
        commit_store_rob_id = head_r;
        if (fire_s) begin
            // A branch with rd=0 already yields index 0, so only stores need masking.
            set_value_id = is_store_r[head_r] ? 5'd0 : rd_r[head_r];
            set_value    = value_r[head_r];
            commit_store = is_store_r[head_r];
        end else begin
            set_value_id = 5'd0;
            set_value    = 32'd0;
            commit_store = 1'b0;
        end
    end

    // Operand query port 1 with same-cycle CDB forwarding.
    always_comb begin
        q1_ready = 1'b0;
        q1_value = 32'd0;
        if (wb_valid && (wb_rob_id == q1_id)) begin
            q1_ready = 1'b1;
            q1_value = wb_value;
        end else begin
            q1_ready = ready_r[q1_id];
            q1_value = value_r[q1_id];
        end
    end

    // Operand query port 2 with same-cycle CDB forwarding.
    always_comb begin
        q2_ready = 1'b0;
        q2_value = 32'd0;
        if (wb_valid && (wb_rob_id == q2_id)) begin
            q2_ready = 1'b1;
            q2_value = wb_value;
        end else begin
            q2_ready = ready_r[q2_id];
            q2_value = value_r[q2_id];
        end
    end

    // Pointer, occupancy, entry and flush state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_r        <= IDX_ZERO;
            tail_r        <= IDX_ZERO;
            count_r       <= CNT_ZERO;
            clear_r       <= 1'b0;
            redirect_pc_r <= 32'd0;
            for (int i = 0; i < SIZE; i++) begin
                busy_r[i]     <= 1'b0;
                ready_r[i]    <= 1'b0;
                rd_r[i]       <= 5'd0;
                value_r[i]    <= 32'd0;
                is_store_r[i] <= 1'b0;
                is_br_r[i]    <= 1'b0;
                pc_r[i]       <= 32'd0;
                pred_pc_r[i]  <= 32'd0;
                next_pc_r[i]  <= 32'd0;
            end
        end else if (rdy_in) begin
            if (clear_r) begin
                clear_r <= 1'b0;
                head_r  <= IDX_ZERO;
                tail_r  <= IDX_ZERO;
                count_r <= CNT_ZERO;
                for (int i = 0; i < SIZE; i++) begin
                    busy_r[i]  <= 1'b0;
                    ready_r[i] <= 1'b0;
                end
            end else begin
                clear_r <= mispredict_s;
                if (mispredict_s) begin
                    redirect_pc_r <= next_pc_r[head_r];
                end
                if (issue_acc_s) begin
                    busy_r[tail_r]     <= 1'b1;
                    ready_r[tail_r]    <= issue_ready;
                    rd_r[tail_r]       <= issue_rd;
                    value_r[tail_r]    <= issue_value;
                    is_store_r[tail_r] <= issue_is_store;
                    is_br_r[tail_r]    <= issue_is_br;
                    pc_r[tail_r]       <= issue_pc;
                    pred_pc_r[tail_r]  <= issue_pred_pc;
                    // Until a writeback says otherwise the prediction is assumed correct.
                    next_pc_r[tail_r]  <= issue_pred_pc;
                    tail_r             <= tail_r + IDX_ONE;
                end
                if (wb_acc_s) begin
                    ready_r[wb_rob_id]   <= 1'b1;
                    value_r[wb_rob_id]   <= wb_value;
                    next_pc_r[wb_rob_id] <= wb_next_pc;
                end
                if (fire_s) begin
                    busy_r[head_r]  <= 1'b0;
                    ready_r[head_r] <= 1'b0;
                    head_r          <= head_r + IDX_ONE;
                end
                case ({issue_acc_s, fire_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular in-order reorder buffer that allocates ROB tags at issue and captures results from the common data bus (CDB) writeback. It retires entries strictly in program order. At retirement it drives the register-file commit interface (set_value_id / set_value / set_value_rob_id) and store-commit pulses. On a branch mispredict it raises the global clear and supplies the redirect PC.

Parameters:
ROB_INDEX_BIT, 3, tag width; depth SIZE = 2**ROB_INDEX_BIT (8)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  ready; when low all state holds, commit outputs forced inactive
issue_valid  in  1  allocate one entry this cycle
issue_rd  in  5  destination reg (0 = none)
issue_is_store  in  1  entry is a store
issue_is_br  in  1  entry is a branch/jump
issue_pc  in  32  instruction PC
issue_pred_pc  in  32  predicted next PC
issue_ready  in  1  result already known at issue (e.g. LUI)
issue_value  in  32  value when issue_ready=1
issue_rob_id  out  ROB_INDEX_BIT  tag to be given to this issue (= tail)
full  out  1  count == SIZE
wb_valid  in  1  CDB result
wb_rob_id  in  ROB_INDEX_BIT  target entry
wb_value  in  32  result
wb_next_pc  in  32  actual next PC (branches)
q1_id, q2_id  in  ROB_INDEX_BIT each  operand tag queries
q1_ready, q2_ready  out  1 each  entry result available
q1_value, q2_value  out  32 each  entry result
set_value_id  out  5  RF write index (0 = no write)
set_value  out  32  RF write data
set_value_rob_id  out  ROB_INDEX_BIT  tag being committed
commit_store  out  1  head store retiring (one-cycle pulse)
commit_store_rob_id  out  ROB_INDEX_BIT  its tag
clear  out  1  registered flush pulse
redirect_pc  out  32  fetch target, valid with clear

Behaviour:
- Per-entry state: busy, ready, rd, value, is_store, is_br, pc, pred_pc, next_pc. Pointers head and tail are ROB_INDEX_BIT wide and wrap modulo SIZE. count is ROB_INDEX_BIT+1 wide.
- Reset: head=tail=count=0, all busy/ready=0, clear=0, redirect_pc=0. All combinational commit outputs read 0 or inactive.
- Issue accept = issue_valid & !full & !clear & rdy_in. On accept, entry[tail] gets busy=1, ready=issue_ready, and the fields from the issue inputs. tail then increments.
  - issue_valid while full is ignored, even if a commit happens the same cycle; full is computed from the current count.
- Writeback: on wb_valid & busy[wb_rob_id] & !clear, store value and next_pc and set ready=1, visible from the next cycle.
  - wb to a non-busy entry is ignored.
- Query ports are combinational: qN_ready = ready[qN_id], qN_value = value[qN_id]. Same-cycle wb is forwarded: if wb_valid & wb_rob_id == qN_id, return ready=1 and wb_value.
- Commit (combinational fire) = rdy_in & !clear & count>0 & ready[head]. When firing:
  - set_value_id = rd[head] unless is_store or is_br-with-rd=0; otherwise 0.
  - set_value = value[head]; set_value_rob_id = head.
  - commit_store = is_store[head]; commit_store_rob_id = head.
  - On the clock edge: busy[head]=0, head increments.
  - When not firing: set_value_id=0, commit_store=0.
- Mispredict: commit of an is_br entry with next_pc != pred_pc. The RF write for that entry still happens that cycle (JAL/JALR link). The next cycle clear=1 and redirect_pc=next_pc, for exactly one cycle.
- While clear=1: head=tail=count=0, all busy/ready cleared, and issue, wb and commit are all suppressed.
- Latency: wb visible to commit 1 cycle later; at most 1 commit per cycle.
- Simultaneous issue and commit: count unchanged.
- Wrap: tail SIZE-1 to 0 with no bubble.
- rdy_in low: no state change, commit outputs inactive, clear held.

Test Plan:
- Reset, then issue rd=5, issue rob_id=0; wb rob0 value 0x1234 -> next cycle set_value_id=5, set_value=0x1234, set_value_rob_id=0; count returns to 0.
- Issue 8 entries -> full=1; 9th issue_valid ignored, tail still 0. Commit head -> full=0; issue the same cycle as full rejected, accepted the cycle after with rob_id=0 (wrap).
- Writebacks out of order to rob2, rob1, rob0 -> commits occur in order 0, 1, 2 on consecutive cycles.
- Branch pred_pc=0x104, wb_next_pc=0x200 -> at commit the RF write occurs; next cycle clear=1, redirect_pc=0x200, count=0; younger wb to a flushed tag is ignored.
- Query q1_id=3 while wb_valid to rob3 value 0xBEEF the same cycle -> q1_ready=1, q1_value=0xBEEF.
- Store entry with wb -> commit_store=1, set_value_id=0; issue rd=0 entry -> set_value_id=0 at commit; rdy_in low with ready head -> no commit until rdy_in returns.
